// File: rtl/decoder_index_sequencer_pkg.sv
// Shared encodings for the decoder index sequencer: sweep modes, one-shot FSM states
// and ping-pong direction.
package decoder_index_sequencer_pkg;

  typedef enum logic [1:0] {
    MODE_UP  = 2'b00,
    MODE_DN  = 2'b01,
    MODE_PP  = 2'b10,
    MODE_ONE = 2'b11
  } mode_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  typedef enum logic {
    DIR_UP = 1'b0,
    DIR_DN = 1'b1
  } dir_e;

  localparam logic [3:0] SEL_MAX = 4'hf;

endpackage

// File: rtl/decoder_index_sequencer_if.sv
// Control/status bundle between a controller (master) and the index sequencer (slave).
interface decoder_index_sequencer_if;
  logic       en;
  logic [1:0] mode;
  logic       load;
  logic [3:0] load_val;
  logic       start;
  logic [3:0] sel;
  logic       step;
  logic       busy;
  logic       done;

  modport master (
    output en, mode, load, load_val, start,
    input  sel, step, busy, done
  );

  modport slave (
    input  en, mode, load, load_val, start,
    output sel, step, busy, done
  );
endinterface

// File: rtl/tick_prescaler.sv
// Free-running 0..DIV-1 counter that emits a combinational tick on its last count.
module tick_prescaler #(
  parameter int unsigned DIV = 4,
  parameter int unsigned CW  = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] pcnt_q, pcnt_d;

  assign tick = en && (pcnt_q == LAST);

  always_comb begin
    pcnt_d = pcnt_q;
    if (clr || tick) begin
      pcnt_d = '0;
    end else if (en) begin
      pcnt_d = pcnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pcnt_q <= '0;
    end else begin
      pcnt_q <= pcnt_d;
    end
  end

endmodule

// File: rtl/decoder_index_sequencer.sv
// Steps the 4-bit select code of a 4-to-16 decoder through up/down/ping-pong/one-shot
// sweeps at a prescaled rate; sel[3:0] maps to decoder inputs w,a,b,c.
module decoder_index_sequencer
  import decoder_index_sequencer_pkg::*;
#(
  parameter int unsigned DIV = 4,
  parameter int unsigned CW  = 8
) (
  input logic                      clk,
  input logic                      rst,
  decoder_index_sequencer_if.slave ctl
);

  mode_e      mode;
  state_e     state_q, state_d;
  dir_e       dir_q, dir_d;
  logic [3:0] sel_q, sel_d;
  logic       step_q, step_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       tick, clr, start_ok;

  assign mode = mode_e'(ctl.mode);

  // A start only restarts the prescaler when it actually launches a sweep.
  assign start_ok = !ctl.load && ctl.start && (mode == MODE_ONE) && (state_q == S_IDLE);
  assign clr      = ctl.load || start_ok;

  tick_prescaler #(
    .DIV (DIV),
    .CW  (CW)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .en   (ctl.en),
    .clr  (clr),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      dir_q   <= DIR_UP;
      sel_q   <= '0;
      step_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      sel_q   <= sel_d;
      step_q  <= step_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (ctl.load || (mode != MODE_ONE)) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (ctl.start) state_d = S_RUN;
        S_RUN:   if (tick && (sel_q == SEL_MAX - 4'd1)) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    sel_d  = sel_q;
    dir_d  = dir_q;
    busy_d = busy_q;
    step_d = 1'b0;
    done_d = 1'b0;
    if (ctl.load) begin
      sel_d  = ctl.load_val;
      dir_d  = DIR_UP;
      busy_d = 1'b0;
    end else begin
      // Leaving one-shot mode mid-sweep abandons it silently.
      if (mode != MODE_ONE) busy_d = 1'b0;
      case (mode)
        MODE_UP: begin
          if (tick) begin
            sel_d  = sel_q + 4'd1;
            step_d = 1'b1;
          end
        end
        MODE_DN: begin
          if (tick) begin
            sel_d  = sel_q - 4'd1;
            step_d = 1'b1;
          end
        end
        MODE_PP: begin
          if (tick) begin
            step_d = 1'b1;
            if (dir_q == DIR_UP) begin
              if (sel_q == SEL_MAX) begin
                sel_d = SEL_MAX - 4'd1;
                dir_d = DIR_DN;
              end else begin
                sel_d = sel_q + 4'd1;
              end
            end else begin
              if (sel_q == 4'd0) begin
                sel_d = 4'd1;
                dir_d = DIR_UP;
              end else begin
                sel_d = sel_q - 4'd1;
              end
            end
          end
        end
        MODE_ONE: begin
          if (state_q == S_IDLE) begin
            if (ctl.start) begin
              sel_d  = 4'd0;
              busy_d = 1'b1;
            end
          end else if (tick) begin
            sel_d  = sel_q + 4'd1;
            step_d = 1'b1;
            if (sel_q == SEL_MAX - 4'd1) begin
              done_d = 1'b1;
              busy_d = 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    ctl.sel  = sel_q;
    ctl.step = step_q;
    ctl.busy = busy_q;
    ctl.done = done_q;
  end

endmodule

// File: doc/decoder_index_sequencer.md
Name: decoder_index_sequencer

Overview:
- Sequential source that generates the 4-bit select code consumed by the team's 4-to-16 line decoder.
- The decoder takes its MSB on input w, then a, b, c, and drives d[15:0].
- This block steps that code through up, down, ping-pong or one-shot sweeps at a programmable rate, so the decoder outputs light one line at a time (LED chaser, row scanner).
- It also supports parallel load and one-shot sweeps with busy/done status.

Parameters:
- DIV, 4, clock cycles per step; legal range 1..256.
- CW, 8, prescaler counter width; must satisfy 2^CW >= DIV.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  step enable; when low, prescaler and position hold.
- mode  input  2  00 up, 01 down, 10 ping-pong, 11 one-shot up.
- load  input  1  parallel-load strobe.
- load_val  input  4  value loaded into sel.
- start  input  1  one-shot launch; used in mode 11 only.
- sel  output  4  current index; wiring to decoder: sel[3]->w, sel[2]->a, sel[1]->b, sel[0]->c.
- step  output  1  one-cycle pulse, high in the first cycle a new sel value is visible due to a tick.
- busy  output  1  high while a one-shot sweep is running.
- done  output  1  one-cycle pulse when a one-shot sweep reaches 15.

Behaviour:
- Reset (rst=1 at a clock edge): sel=0, step=0, busy=0, done=0, prescaler=0, dir=UP, FSM=IDLE. Reset overrides every other input.
- Prescaler:
  - While en=1, counts 0..DIV-1.
  - tick is internal and combinational: tick = en && (pcnt == DIV-1).
  - On tick, pcnt returns to 0.
  - DIV=1 gives a tick every enabled cycle.
  - When en=0, pcnt holds and no tick is generated.
- Latency: sel and step update on the edge where tick=1, so the new value appears one cycle after the final prescaler count. All outputs are registered.
- Mode 00 (up): sel <= sel+1 on tick; wraps 15->0.
- Mode 01 (down): sel <= sel-1 on tick; wraps 0->15.
- Mode 10 (ping-pong): 1-bit dir register.
  - dir=UP: sel+1; if sel==15 then sel<=14, dir<=DN.
  - dir=DN: sel-1; if sel==0 then sel<=1, dir<=UP.
  - End values are therefore visited once per turnaround: 14,15,14 and 1,0,1.
- Mode 11 (one-shot), FSM IDLE/RUN:
  - IDLE: ticks do not move sel. start=1 -> sel<=0, pcnt<=0, busy<=1, go to RUN. No step pulse on start.
  - RUN: on tick, sel+1 with step. The tick that moves sel 14->15 also sets done=1 for one cycle, busy<=0, and returns to IDLE.
  - sel holds 15 afterwards.
  - start while in RUN is ignored.
- Load (load=1):
  - sel<=load_val, pcnt<=0, dir<=UP, FSM<=IDLE, busy<=0.
  - No step or done pulse.
  - Load has priority over tick and start in the same cycle.
- Mode change:
  - Sampled every cycle; takes effect on the next tick.
  - Changing mode away from 11 while in RUN forces IDLE and busy<=0, with no done pulse.
  - dir is retained across changes into mode 10.
- step and done are never high for more than one consecutive cycle unless DIV=1. With DIV=1, step may stay high continuously.

Decomposition:
- Shared include file: mode encodings (MODE_UP=2'b00, MODE_DN=2'b01, MODE_PP=2'b10, MODE_ONE=2'b11), FSM state encodings (S_IDLE, S_RUN) and dir encodings (DIR_UP, DIR_DN).
- One sub-module: tick_prescaler.
  - Parameters DIV, CW; ports clk, rst, en, clr, tick.
  - clr is driven by load, or by start accepted in IDLE.
- Index, direction and FSM logic stay in the top module.

Test Plan:
- Reset: assert rst for 2 cycles with en=1 -> sel=0, step=0, busy=0, done=0. Release, mode=00, DIV=4 -> sel=1 with step on the 4th edge after release, then 2 on the 8th.
- Up wrap: load_val=14, pulse load, mode=00, en=1 -> sel sequence 14,15,0,1 at 4-cycle spacing; step pulses exactly on each change. Repeat in mode=01 from 1 -> sequence 1,0,15.
- Ping-pong: load 13, mode=10 -> sequence 13,14,15,14,13. Reload 2 and force dir down via the turnaround -> sequence ...,1,0,1,2.
- Load priority: align load=1 (load_val=9) with a tick cycle -> sel=9 next cycle, no step pulse; next step occurs DIV cycles later with sel=10.
- One-shot: mode=11, pulse start -> busy=1 and sel=0; after 15 ticks sel=15, done pulses once, busy=0. A further 8 ticks leave sel=15 with no step. A start issued mid-sweep does not restart the sweep.
- Enable hold and mid-operation reset: drop en for 10 cycles mid-count -> sel and phase unchanged. Then assert rst during a RUN sweep -> all outputs at reset values the next cycle, with no done pulse.
